// File: rtl/cpu_sequencer_if.sv
// Handshake and status bundle between the CPU sequencer and its environment.
interface cpu_sequencer_if #(
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   enable;
  logic                   mem_ack;
  logic [3:0]             instr_in;
  logic [2:0]             state;
  logic                   mem_req;
  logic                   ir_load;
  logic                   alu_en;
  logic                   reg_we;
  logic                   pc_inc;
  logic [COUNT_WIDTH-1:0] count;
  logic                   halted;
  logic                   fault;

  // Sequencer side: it masters the memory request.
  modport master (
    input  enable, mem_ack, instr_in,
    output state, mem_req, ir_load, alu_en, reg_we, pc_inc, count, halted, fault
  );

  // Environment side: run control, memory responder and observer.
  modport slave (
    output enable, mem_ack, instr_in,
    input  state, mem_req, ir_load, alu_en, reg_we, pc_inc, count, halted, fault
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback with
// a memory-wait timeout that traps into an absorbing HALT state.
module cpu_sequencer #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             opcode_q, opcode_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   fault_q, fault_d;
  logic                   timeout_c;

  // An ack on the final allowed cycle wins over the timeout.
  assign timeout_c = (wait_q == WAIT_W'(MEM_TIMEOUT)) && !bus.mem_ack;

  // Next-state, datapath register updates; wait counter is zero outside FETCH/MEM.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    wait_d   = '0;
    count_d  = count_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          opcode_d = bus.instr_in;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (opcode_q == 4'hF)  state_d = S_HALT;
        else if (opcode_q[3])  state_d = S_MEM;
        else                   state_d = S_WRITEBACK;
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          state_d = S_WRITEBACK;
        end else if (timeout_c) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        count_d = count_q + COUNT_WIDTH'(1);
        state_d = bus.enable ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      wait_q   <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  // Moore decodes of the state register; ir_load also qualifies with mem_ack.
  assign bus.state   = state_q;
  assign bus.mem_req = (state_q == S_FETCH) || (state_q == S_MEM);
  assign bus.ir_load = (state_q == S_FETCH) && bus.mem_ack;
  assign bus.alu_en  = (state_q == S_EXECUTE);
  assign bus.reg_we  = (state_q == S_WRITEBACK);
  assign bus.pc_inc  = (state_q == S_WRITEBACK);
  assign bus.halted  = (state_q == S_HALT);
  assign bus.count   = count_q;
  assign bus.fault   = fault_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 8, width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ack before fault.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  run permission; sampled in IDLE and at the end of WRITEBACK.
REQ-006 mem_ack  input  1  memory handshake acknowledge; single-cycle pulse or level.
REQ-007 instr_in  input  4  opcode from memory, valid when mem_ack is high in FETCH.
REQ-008 state  output  3  current state encoding.
REQ-009 mem_req  output  1  memory request, high throughout FETCH and MEM.
REQ-010 ir_load  output  1  instruction-register load strobe.
REQ-011 alu_en  output  1  ALU enable strobe.
REQ-012 reg_we  output  1  register-file write strobe.
REQ-013 pc_inc  output  1  program-counter increment strobe.
REQ-014 count  output  COUNT_WIDTH  retired-instruction count.
REQ-015 halted  output  1  high in HALT.
REQ-016 fault  output  1  sticky memory-timeout flag.

Function
REQ-017 The block SHALL use these encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. Code 7 is illegal and SHALL transition to IDLE.
REQ-018 IDLE -> FETCH when enable=1. Otherwise the block SHALL stay in IDLE.
REQ-019 In FETCH, mem_req=1. On mem_ack=1, ir_load=1 for that cycle only (combinational from state and mem_ack), instr_in is latched into an internal opcode register, and the next state is DECODE.
REQ-020 DECODE SHALL last exactly 1 cycle, then go to EXECUTE.
REQ-021 In EXECUTE, alu_en=1 for 1 cycle. Next state:
  - HALT if opcode=4'hF.
  - MEM if opcode[3]=1 and opcode!=4'hF.
  - WRITEBACK otherwise.
REQ-022 In MEM, mem_req=1 until mem_ack=1, then WRITEBACK.
REQ-023 In WRITEBACK, reg_we=1 and pc_inc=1 for 1 cycle, and count increments by 1. Next state is FETCH if enable=1, else IDLE.
REQ-024 count SHALL wrap from 2^COUNT_WIDTH-1 to 0 with no flag.
REQ-025 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ack=0 while in FETCH or MEM.
REQ-026 When the wait counter reaches MEM_TIMEOUT with mem_ack=0, the next state SHALL be HALT and fault SHALL be set.
REQ-027 mem_ack=1 on the same cycle the timeout would fire SHALL count as success: no fault.
REQ-028 enable deassertion mid-instruction SHALL NOT abort the instruction; it takes effect only at the end of WRITEBACK.
REQ-029 HALT is absorbing (halted=1), left only by reset. All strobes and mem_req SHALL be 0 in HALT.
REQ-030 Minimum instruction latency with zero-wait memory SHALL be:
  - 4 cycles for non-memory ops (FETCH, DECODE, EXECUTE, WRITEBACK).
  - 5 cycles for memory ops.
REQ-031 Strobes (alu_en, reg_we, pc_inc) SHALL be Moore outputs decoded from the state register and SHALL never be high outside their state.

Reset
REQ-032 When rst_n=0, the block SHALL immediately (asynchronously) set:
  - state=IDLE
  - count=0
  - opcode register=0
  - wait counter=0
  - fault=0
  - halted=0
  - all strobes and mem_req=0
REQ-033 Reset asserted mid-instruction, including in MEM with mem_req high, SHALL drop mem_req immediately and discard the instruction without incrementing count.
REQ-034 After rst_n rises, the first transition SHALL occur on the next rising clk edge.

Verification
REQ-035 Reset then enable=1, mem_ack tied 1, instr_in=4'h1 -> state sequence 1,2,3,5 repeating; count=3 after 12 cycles.
REQ-036 instr_in=4'h8, mem_ack delayed 2 cycles in MEM -> mem_req high 3 cycles in MEM, then WRITEBACK, count +1.
REQ-037 instr_in=4'hF -> after EXECUTE, state=6 and halted=1; count unchanged; stays in HALT for 20 cycles.
REQ-038 mem_ack held 0 in FETCH -> state=6 and fault=1 after 16 cycles; mem_ack on the 16th cycle instead -> DECODE, fault=0.
REQ-039 enable dropped during DECODE -> instruction completes, then IDLE. Also, preload count to 255 via 255 instructions -> the next retire gives count=0.
REQ-040 rst_n pulsed low in MEM -> mem_req=0 within the same cycle, state=0, count held at 0 after the reset sequence.
